// File: rtl/pool_pingpong_buffer.sv
// pool_pingpong_buffer: two-bank frame store; ports i_wr_* write stream in, o_wr_ready/o_wr_count/o_overflow writer status, i_rd_en/i_rd_addr/i_rd_done random read + release, o_rd_* registered read data
module pool_pingpong_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 3025,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic [ADDR_W-1:0] o_wr_count,
  output logic              o_overflow,
  output logic              o_rd_frame_ready,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid,
  input  logic              i_rd_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [ADDR_W-1:0] r_wr_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_wr_ready;
  logic              w_wr;
  logic              w_last;
  logic              w_frame_ready;
  logic              w_rd;
  logic              w_rel;
  logic              w_addr_ok;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  always_comb begin
    w_wr_ready    = !r_full[r_wr_sel];
    w_wr          = i_wr_valid && w_wr_ready;
    w_last        = r_wr_count == LAST;
    w_frame_ready = r_full[r_rd_sel];
    w_rd          = i_rd_en && w_frame_ready;
    w_rel         = i_rd_done && w_frame_ready;
    w_addr_ok     = i_rd_addr <= LAST;
    w_set         = (w_wr && w_last) ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
    w_clr         = w_rel ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!rst && w_wr && r_wr_sel) r_bank1[r_wr_count] <= i_wr_data;
    if (!rst && w_wr && !r_wr_sel) r_bank0[r_wr_count] <= i_wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full     <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_wr_count <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_full     <= (r_full | w_set) & ~w_clr;
      r_rd_valid <= w_rd;
      if (w_wr) begin
        r_wr_count <= w_last ? '0 : r_wr_count + 1'b1;
        r_wr_sel   <= r_wr_sel ^ w_last;
      end
      if (w_rel) r_rd_sel <= ~r_rd_sel;
      if (i_wr_valid && !w_wr_ready) r_overflow <= 1'b1;
      if (w_rd) r_rd_data <= w_addr_ok ? (r_rd_sel ? r_bank1[i_rd_addr] : r_bank0[i_rd_addr]) : '0;
    end
  end
  assign o_wr_ready       = w_wr_ready;
  assign o_wr_count       = r_wr_count;
  assign o_overflow       = r_overflow;
  assign o_rd_frame_ready = w_frame_ready;
  assign o_rd_data        = r_rd_data;
  assign o_rd_data_valid  = r_rd_valid;
endmodule

// File: tb/tb_pool_pingpong_buffer.sv
// tb_pool_pingpong_buffer: directed vectors on a DEPTH=9 instance plus a full-size single-frame run
module tb_pool_pingpong_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        s_rst, s_wr_valid, s_wr_ready, s_overflow, s_frdy, s_rd_en, s_rv, s_rd_done;
  logic [15:0] s_wr_data, s_rd_data;
  logic [3:0]  s_wr_count, s_rd_addr;
  logic        b_rst, b_wr_valid, b_wr_ready, b_overflow, b_frdy, b_rd_en, b_rv, b_rd_done;
  logic [15:0] b_wr_data, b_rd_data;
  logic [11:0] b_wr_count, b_rd_addr;
  pool_pingpong_buffer #(.DATA_W(16), .DEPTH(9), .ADDR_W(4)) u_small (
    .clk(clk), .rst(s_rst), .i_wr_valid(s_wr_valid), .i_wr_data(s_wr_data),
    .o_wr_ready(s_wr_ready), .o_wr_count(s_wr_count), .o_overflow(s_overflow),
    .o_rd_frame_ready(s_frdy), .i_rd_en(s_rd_en), .i_rd_addr(s_rd_addr),
    .o_rd_data(s_rd_data), .o_rd_data_valid(s_rv), .i_rd_done(s_rd_done));
  pool_pingpong_buffer #(.DATA_W(16), .DEPTH(3025), .ADDR_W(12)) u_big (
    .clk(clk), .rst(b_rst), .i_wr_valid(b_wr_valid), .i_wr_data(b_wr_data),
    .o_wr_ready(b_wr_ready), .o_wr_count(b_wr_count), .o_overflow(b_overflow),
    .o_rd_frame_ready(b_frdy), .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr),
    .o_rd_data(b_rd_data), .o_rd_data_valid(b_rv), .i_rd_done(b_rd_done));
  typedef struct {
    logic        rst, wv;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic        rdn, e_rdy;
    logic [3:0]  e_cnt;
    logic        e_ovf, e_frdy, e_rv;
    logic [15:0] e_rd;
  } vec_t;
  vec_t q[$];
  int checks = 0;
  int errors = 0;
  function automatic void add(input int rst, wv, wd, re, ra, rdn, rdy, cnt, ovf, frdy, rv, rd);
    q.push_back('{rst[0], wv[0], wd[15:0], re[0], ra[3:0], rdn[0], rdy[0], cnt[3:0], ovf[0], frdy[0], rv[0], rd[15:0]});
  endfunction
  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  initial begin
    s_rst = 1'b1; s_wr_valid = 1'b0; s_wr_data = '0; s_rd_en = 1'b0; s_rd_addr = '0; s_rd_done = 1'b0;
    b_rst = 1'b1; b_wr_valid = 1'b0; b_wr_data = '0; b_rd_en = 1'b0; b_rd_addr = '0; b_rd_done = 1'b0;
    add(1,0,0,0,0,0, 1,0,0,0,0,0);
    add(0,0,0,0,0,1, 1,0,0,0,0,0);
    add(0,0,0,1,0,0, 1,0,0,0,0,0);
    for (int i = 0; i < 9; i++) add(0,1,'h10+i,0,0,0, 1,(i+1)%9,0,int'(i==8),0,0);
    for (int i = 0; i < 9; i++) add(0,1,'h20+i,1,i,0, int'(i!=8),(i+1)%9,0,1,1,'h10+i);
    add(0,0,0,1,9,0, 0,0,0,1,1,0);
    add(0,1,'h77,0,0,0, 0,0,1,1,0,0);
    add(0,1,'h99,1,4,1, 1,0,1,1,1,'h14);
    add(0,0,0,1,0,0, 1,0,1,1,1,'h20);
    add(0,0,0,0,0,0, 1,0,1,1,0,'h20);
    for (int i = 0; i < 8; i++) add(0,1,'h30+i,0,0,0, 1,i+1,1,1,0,'h20);
    add(0,1,'h38,0,0,1, 1,0,1,1,0,'h20);
    add(0,0,0,1,0,0, 1,0,1,1,1,'h30);
    add(0,0,0,1,8,0, 1,0,1,1,1,'h38);
    for (int i = 0; i < 5; i++) add(0,1,'h50+i,0,0,0, 1,i+1,1,1,0,'h38);
    add(1,1,'h66,1,0,1, 1,0,0,0,0,0);
    for (int i = 0; i < 9; i++) add(0,1,'h40+i,0,0,0, 1,(i+1)%9,0,int'(i==8),0,0);
    add(0,0,0,1,0,0, 1,0,0,1,1,'h40);
    add(0,0,0,1,8,0, 1,0,0,1,1,'h48);
    for (int k = 0; k < q.size(); k++) begin
      s_rst = q[k].rst; s_wr_valid = q[k].wv; s_wr_data = q[k].wd;
      s_rd_en = q[k].re; s_rd_addr = q[k].ra; s_rd_done = q[k].rdn;
      @(posedge clk); #1;
      chk("wr_ready", k, 16'(s_wr_ready), 16'(q[k].e_rdy));
      chk("wr_count", k, 16'(s_wr_count), 16'(q[k].e_cnt));
      chk("overflow", k, 16'(s_overflow), 16'(q[k].e_ovf));
      chk("frame_ready", k, 16'(s_frdy), 16'(q[k].e_frdy));
      chk("rd_valid", k, 16'(s_rv), 16'(q[k].e_rv));
      chk("rd_data", k, s_rd_data, q[k].e_rd);
    end
    s_rst = 1'b0; s_wr_valid = 1'b0; s_rd_en = 1'b0; s_rd_done = 1'b0;
    @(posedge clk); #1;
    chk("big_reset_ready", 0, 16'(b_wr_ready), 16'd1);
    chk("big_reset_frdy", 0, 16'(b_frdy), 16'd0);
    b_rst = 1'b0;
    for (int i = 0; i < 3025; i++) begin
      b_wr_valid = 1'b1; b_wr_data = 16'(i);
      @(posedge clk); #1;
      if (i == 3023) begin
        chk("big_count_3024", i, 16'(b_wr_count), 16'd3024);
        chk("big_frdy_early", i, 16'(b_frdy), 16'd0);
      end
    end
    b_wr_valid = 1'b0;
    chk("big_frdy", 0, 16'(b_frdy), 16'd1);
    chk("big_count_wrap", 0, 16'(b_wr_count), 16'd0);
    chk("big_wr_ready", 0, 16'(b_wr_ready), 16'd1);
    b_rd_en = 1'b1; b_rd_addr = 12'd0;
    @(posedge clk); #1;
    chk("big_rd0_valid", 0, 16'(b_rv), 16'd1);
    chk("big_rd0_data", 0, b_rd_data, 16'h0000);
    b_rd_addr = 12'd3024;
    @(posedge clk); #1;
    chk("big_rd3024_valid", 0, 16'(b_rv), 16'd1);
    chk("big_rd3024_data", 0, b_rd_data, 16'h0BD0);
    b_rd_en = 1'b0;
    @(posedge clk); #1;
    chk("big_idle_valid", 0, 16'(b_rv), 16'd0);
    chk("big_idle_hold", 0, b_rd_data, 16'h0BD0);
    chk("big_overflow", 0, 16'(b_overflow), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_pingpong_buffer.md
Name: pool_pingpong_buffer

Overview:
- Double-buffered feature-map store between the 3x3/stride-2 max-pool stage and the 1x1 squeeze stage.
- Captures one pooled channel frame (55x55 = 3025 samples, raster order) from the pool output stream into one bank.
- While that bank is being written, the squeeze stage reads the other bank by random address.
- Banks swap on frame completion and consumer release. The buffer never stalls the producer; writes it cannot accept are dropped and flagged.

Parameters:
- DATA_W, 16, sample width (fixed-point as produced by max-pool).
- DEPTH, 3025, samples per frame (55*55).
- ADDR_W, 12, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  producer sample strobe (max-pool o_max_data_valid).
- wr_data  in  DATA_W  producer sample.
- wr_ready  out  1  write bank is free (combinational: !full[wr_sel]).
- wr_count  out  ADDR_W  samples written into current write bank.
- overflow  out  1  sticky; a sample was dropped.
- rd_frame_ready  out  1  read bank holds a complete frame (full[rd_sel]).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address, raster index 0..DEPTH-1.
- rd_data  out  DATA_W  read data, registered.
- rd_data_valid  out  1  rd_data valid this cycle.
- rd_done  in  1  consumer releases current read bank.

Behaviour:
- Storage: two banks of DEPTH x DATA_W (inferred RAM). Per-bank full bit. 1-bit pointers wr_sel and rd_sel.
- Reset (any cycle, including mid-frame):
  - full[0]=full[1]=0; wr_sel=rd_sel=0; wr_count=0.
  - rd_data=0, rd_data_valid=0, overflow=0.
  - A partial frame is discarded. Bank contents are not cleared.
- Write, when wr_valid && wr_ready:
  - bank[wr_sel][wr_count] <= wr_data.
  - If wr_count==DEPTH-1: wr_count<=0, full[wr_sel]<=1, wr_sel toggles.
  - Otherwise wr_count increments.
- Drop, when wr_valid && !wr_ready: sample discarded, wr_count unchanged, overflow<=1 (cleared only by rst).
- Write states per bank are implied by the full bit: FILLING (wr_sel points at it, not full), FULL (full=1), FREE.
- Read, when rd_en && rd_frame_ready:
  - Next cycle: rd_data <= bank[rd_sel][rd_addr], rd_data_valid=1.
  - Latency exactly 1 cycle; back-to-back reads give one result per cycle.
  - rd_addr >= DEPTH returns rd_data=0 with rd_data_valid=1.
- rd_en while !rd_frame_ready: ignored, rd_data_valid=0 next cycle, rd_data holds its last value.
- rd_data_valid deasserts the cycle after any cycle without an accepted read.
- Release, when rd_done && rd_frame_ready: full[rd_sel]<=0, rd_sel toggles. rd_done while !rd_frame_ready is ignored.
- Simultaneous events:
  - rd_en and rd_done in the same cycle: the read is served from the bank being released (bank select is sampled with the address).
  - Writer completes a frame into one bank while the reader releases the other: both updates apply.
  - Release of the bank wr_sel is waiting on: frees it from the next cycle; a write in the release cycle is still dropped (wr_ready was 0).
  - Write and read to different banks in the same cycle: independent, no hazard. The same bank is never both written and read, since a full bank is not written.
- Ordering: frames are consumed in write order. rd_sel always trails or equals wr_sel.

Test Plan:
- Single frame: DEPTH=3025, stream wr_data=index for 3025 cycles.
  - rd_frame_ready=1 the cycle after the 3025th write; wr_sel=1; wr_count=0.
  - Read addr 0 -> 0x0000, addr 3024 -> 0x0BD0, each 1 cycle later with rd_data_valid=1.
- Ping-pong overlap: DEPTH=9, write frame A (0x10..0x18), then stream frame B while reading A at addrs 0..8.
  - Reads return 0x10..0x18.
  - rd_done then exposes B; first read of B returns B's first sample.
- Overflow: DEPTH=9, write 18 samples with no rd_done.
  - wr_ready=0 after the 18th.
  - 19th sample is dropped; overflow=1 and stays set.
  - rd_done -> wr_ready=1 next cycle; the following write lands at wr_count 0.
- Boundary reads:
  - rd_en with rd_frame_ready=0 -> rd_data_valid=0.
  - rd_addr=DEPTH -> rd_data=0, valid=1.
  - rd_en+rd_done same cycle at addr 4 -> data from the released bank.
- Reset mid-frame: DEPTH=9, write 5 samples, assert rst 1 cycle.
  - All outputs return to reset values, wr_count=0.
  - The next 9 writes form a complete frame at bank 0.
